// File: rtl/nic_pkg.sv
// Shared definitions for the network interface: register map, status layout, packet VC bit.
package nic_pkg;

    typedef enum logic [1:0] {
        NIC_IN_DATA  = 2'b00,
        NIC_IN_STAT  = 2'b01,
        NIC_OUT_DATA = 2'b10,
        NIC_OUT_STAT = 2'b11
    } nic_addr_e;

    // Status word layout, LSB upward: empty/nonempty flag, full flag, count, then overflow
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_CNT_LSB   = 2;

    // Packet bit 0 in MSB-first numbering is the top bit of a descending vector
    function automatic int vc_bit(input int width);
        return width - 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nic_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module nic_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap naturally
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/nic_fifo.sv
// Network interface: CPU register port, router handshake, VC-gated send FSM, sticky overflow.
//   state   | meaning
//   IDLE    | no packet on net_so; may launch the out-FIFO head this edge
//   SEND    | net_so high for this one cycle; forces an idle cycle before the next send
module nic_fifo
    import nic_pkg::*;
#(
    parameter int PACKET_WIDTH = 64,
    parameter int IN_DEPTH     = 4,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              addr,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic                    nicEn,
    input  logic                    nicEnWR,
    input  logic                    net_si,
    output logic                    net_ri,
    input  logic [PACKET_WIDTH-1:0] net_di,
    output logic                    net_so,
    input  logic                    net_ro,
    output logic [PACKET_WIDTH-1:0] net_do,
    input  logic                    net_polarity
);
    localparam int CNT_W  = $clog2(max2(IN_DEPTH, OUT_DEPTH)) + 1;
    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;
    localparam int VC     = vc_bit(PACKET_WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [PACKET_WIDTH-1:0] in_head, out_head;
    logic [IN_CW-1:0]        in_count;
    logic [OUT_CW-1:0]       out_count;
    logic [CNT_W-1:0]        in_cnt_ext, out_cnt_ext;
    logic                    in_full, in_empty, out_full, out_empty;
    logic                    in_push, in_pop, out_push, out_pop;
    logic                    rd_en, wr_out, ovf_set, send_go;

    logic [0:0]              state_q, state_d;
    logic [PACKET_WIDTH-1:0] d_out_q, d_out_d;
    logic [PACKET_WIDTH-1:0] net_do_q, net_do_d;
    logic                    ovf_q, ovf_d;

    assign in_cnt_ext  = CNT_W'(in_count);
    assign out_cnt_ext = CNT_W'(out_count);

    assign net_ri  = !in_full;
    assign rd_en   = nicEn && !nicEnWR;
    assign wr_out  = nicEn && nicEnWR && (addr == NIC_OUT_DATA);
    assign in_push = net_si && net_ri;
    assign in_pop  = rd_en && (addr == NIC_IN_DATA) && !in_empty;
    assign out_push = wr_out && !out_full;
    assign ovf_set  = wr_out && out_full;

    assign send_go = (state_q == ST_IDLE) && !out_empty && net_ro
                     && (net_polarity == out_head[VC]);
    assign out_pop = send_go;

    nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (in_push),
        .pop_i   (in_pop),
        .data_i  (net_di),
        .head_o  (in_head),
        .count_o (in_count),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (out_push),
        .pop_i   (out_pop),
        .data_i  (d_in),
        .head_o  (out_head),
        .count_o (out_count),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

    always_comb begin
        d_out_d = d_out_q;
        if (rd_en) begin
            d_out_d = '0;
            case (nic_addr_e'(addr))
                NIC_IN_DATA: d_out_d = in_empty ? '0 : in_head;
                NIC_IN_STAT: begin
                    d_out_d[STAT_EMPTY_BIT]              = !in_empty;
                    d_out_d[STAT_FULL_BIT]               = in_full;
                    d_out_d[STAT_CNT_LSB +: CNT_W]       = in_cnt_ext;
                end
                NIC_OUT_DATA: d_out_d = '0;
                NIC_OUT_STAT: begin
                    d_out_d[STAT_EMPTY_BIT]              = out_empty;
                    d_out_d[STAT_FULL_BIT]               = out_full;
                    d_out_d[STAT_CNT_LSB +: CNT_W]       = out_cnt_ext;
                    d_out_d[STAT_CNT_LSB + CNT_W]        = ovf_q;
                end
            endcase
        end
    end

    // A dropped write in the same cycle as the status read keeps the flag set
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (rd_en && (addr == NIC_OUT_STAT)) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = send_go ? ST_SEND : ST_IDLE;
        net_do_d = send_go ? out_head : net_do_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            d_out_q  <= '0;
            net_do_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_out_q  <= d_out_d;
            net_do_q <= net_do_d;
            ovf_q    <= ovf_d;
        end
    end

    assign d_out  = d_out_q;
    assign net_do = net_do_q;
    assign net_so = (state_q == ST_SEND);

endmodule
